// File: rtl/scoreboard_ctrl_if.sv
// Issue and functional-unit handshake bundle for scoreboard_ctrl.
// The master (decoder/FU side) drives issue requests and fu_done; the slave is the scoreboard.
interface scoreboard_ctrl_if #(
  parameter int REG_W  = 3,
  parameter int NUM_FU = 3,
  parameter int FU_W   = 2
);
  logic              issue_valid;
  logic              issue_is_mem;
  logic [REG_W-1:0]  issue_dest;
  logic [REG_W-1:0]  issue_src0;
  logic [REG_W-1:0]  issue_src1;
  logic              issue_ready;
  logic [FU_W-1:0]   issue_fu;
  logic [NUM_FU-1:0] fu_done;
  logic [NUM_FU-1:0] fu_read_go;
  logic [NUM_FU-1:0] fu_write_go;
  logic [NUM_FU-1:0] fu_busy;

  modport master (
    output issue_valid, issue_is_mem, issue_dest, issue_src0, issue_src1, fu_done,
    input  issue_ready, issue_fu, fu_read_go, fu_write_go, fu_busy
  );

  modport slave (
    input  issue_valid, issue_is_mem, issue_dest, issue_src0, issue_src1, fu_done,
    output issue_ready, issue_fu, fu_read_go, fu_write_go, fu_busy
  );
endinterface

// File: rtl/scoreboard_ctrl.sv
// Classic scoreboard controller: per-FU issue/read/execute/writeback tracking with
// RAW, WAR, WAW and structural hazard interlocks driven from registered state.
module scoreboard_ctrl #(
  parameter int                NUM_REGS    = 8,
  parameter int                REG_W       = 3,
  parameter int                NUM_FU      = 3,
  parameter int                FU_W        = 2,
  parameter logic [NUM_FU-1:0] FU_IS_MEM   = 3'b100,
  parameter int                NOWRITE_REG = 7
) (
  input  logic             clk,
  input  logic             reset,
  scoreboard_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_OPS = 2'd1,
    ST_EXEC     = 2'd2,
    ST_WAIT_WB  = 2'd3
  } fu_state_e;

  localparam logic [FU_W-1:0]  FU_FREE = FU_W'(NUM_FU);
  localparam logic [REG_W-1:0] NO_WR   = REG_W'(NOWRITE_REG);

  // Op class is implied by FU_IS_MEM, so only operand bookkeeping is stored per FU.
  fu_state_e         r_state   [NUM_FU];
  logic [REG_W-1:0]  r_fi      [NUM_FU];
  logic [REG_W-1:0]  r_fj      [NUM_FU];
  logic [REG_W-1:0]  r_fk      [NUM_FU];
  logic [FU_W-1:0]   r_qj      [NUM_FU];
  logic [FU_W-1:0]   r_qk      [NUM_FU];
  logic [NUM_FU-1:0] r_rj;
  logic [NUM_FU-1:0] r_rk;
  logic [FU_W-1:0]   r_regstat [NUM_REGS];

  fu_state_e         w_state_nx   [NUM_FU];
  logic [REG_W-1:0]  w_fi_nx      [NUM_FU];
  logic [REG_W-1:0]  w_fj_nx      [NUM_FU];
  logic [REG_W-1:0]  w_fk_nx      [NUM_FU];
  logic [FU_W-1:0]   w_qj_nx      [NUM_FU];
  logic [FU_W-1:0]   w_qk_nx      [NUM_FU];
  logic [NUM_FU-1:0] w_rj_nx;
  logic [NUM_FU-1:0] w_rk_nx;
  logic [FU_W-1:0]   w_regstat_nx [NUM_REGS];

  logic [NUM_FU-1:0] w_read_go;
  logic [NUM_FU-1:0] w_write_go;
  logic [NUM_FU-1:0] w_busy;
  logic [NUM_FU-1:0] w_war;
  logic [NUM_FU-1:0] w_set_rj;
  logic [NUM_FU-1:0] w_set_rk;
  logic              w_has_cand;
  logic [FU_W-1:0]   w_sel_fu;
  logic [FU_W-1:0]   w_src0_q;
  logic [FU_W-1:0]   w_src1_q;
  logic [FU_W-1:0]   w_dest_q;
  logic              w_issue_ready;
  logic              w_fire;
  logic              w_rj_iss;
  logic              w_rk_iss;

  // Per-FU read/write pulses, busy flags and writeback-driven operand wakeups.
  always_comb begin
    w_read_go  = '0;
    w_write_go = '0;
    w_busy     = '0;
    w_war      = '0;
    w_set_rj   = '0;
    w_set_rk   = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      w_busy[i]    = (r_state[i] != ST_IDLE);
      w_read_go[i] = (r_state[i] == ST_WAIT_OPS) && r_rj[i] && r_rk[i];
      for (int f = 0; f < NUM_FU; f++) begin
        w_war[i] = w_war[i] | ((f != i) &&
                   (((r_fj[f] == r_fi[i]) && r_rj[f]) || ((r_fk[f] == r_fi[i]) && r_rk[f])));
      end
      w_write_go[i] = (r_state[i] == ST_WAIT_WB) && ((r_fi[i] == NO_WR) || !w_war[i]);
    end
    for (int i = 0; i < NUM_FU; i++) begin
      for (int f = 0; f < NUM_FU; f++) begin
        w_set_rj[i] = w_set_rj[i] | (w_write_go[f] && (r_qj[i] == FU_W'(f)));
        w_set_rk[i] = w_set_rk[i] | (w_write_go[f] && (r_qk[i] == FU_W'(f)));
      end
    end
  end

  // Issue candidate selection, producer lookups and same-cycle writeback bypass.
  always_comb begin
    w_has_cand = 1'b0;
    w_sel_fu   = FU_FREE;
    w_src0_q   = FU_FREE;
    w_src1_q   = FU_FREE;
    w_dest_q   = FU_FREE;
    for (int i = NUM_FU - 1; i >= 0; i--) begin
      if ((r_state[i] == ST_IDLE) && (FU_IS_MEM[i] == bus.issue_is_mem)) begin
        w_has_cand = 1'b1;
        w_sel_fu   = FU_W'(i);
      end else begin
        w_has_cand = w_has_cand;
      end
    end
    for (int r = 0; r < NUM_REGS; r++) begin
      w_src0_q = (bus.issue_src0 == REG_W'(r)) ? r_regstat[r] : w_src0_q;
      w_src1_q = (bus.issue_src1 == REG_W'(r)) ? r_regstat[r] : w_src1_q;
      w_dest_q = (bus.issue_dest == REG_W'(r)) ? r_regstat[r] : w_dest_q;
    end
    w_issue_ready = w_has_cand && ((bus.issue_dest == NO_WR) || (w_dest_q == FU_FREE));
    w_fire        = bus.issue_valid && w_issue_ready;
    w_rj_iss      = (w_src0_q == FU_FREE);
    w_rk_iss      = (w_src1_q == FU_FREE);
    for (int f = 0; f < NUM_FU; f++) begin
      w_rj_iss = w_rj_iss | (w_write_go[f] && (w_src0_q == FU_W'(f)));
      w_rk_iss = w_rk_iss | (w_write_go[f] && (w_src1_q == FU_W'(f)));
    end
  end

  // Next-state logic for every FU and the register producer table.
  always_comb begin
    w_state_nx   = r_state;
    w_fi_nx      = r_fi;
    w_fj_nx      = r_fj;
    w_fk_nx      = r_fk;
    w_qj_nx      = r_qj;
    w_qk_nx      = r_qk;
    w_rj_nx      = r_rj;
    w_rk_nx      = r_rk;
    w_regstat_nx = r_regstat;
    for (int i = 0; i < NUM_FU; i++) begin
      case (r_state[i])
        ST_IDLE: begin
          if (w_fire && (w_sel_fu == FU_W'(i))) begin
            w_state_nx[i] = ST_WAIT_OPS;
            w_fi_nx[i]    = bus.issue_dest;
            w_fj_nx[i]    = bus.issue_src0;
            w_fk_nx[i]    = bus.issue_src1;
            w_qj_nx[i]    = w_src0_q;
            w_qk_nx[i]    = w_src1_q;
            w_rj_nx[i]    = w_rj_iss;
            w_rk_nx[i]    = w_rk_iss;
          end else begin
            w_state_nx[i] = ST_IDLE;
          end
        end
        ST_WAIT_OPS: begin
          if (w_read_go[i]) begin
            w_state_nx[i] = ST_EXEC;
            w_rj_nx[i]    = 1'b0;
            w_rk_nx[i]    = 1'b0;
          end else begin
            w_rj_nx[i] = r_rj[i] | w_set_rj[i];
            w_rk_nx[i] = r_rk[i] | w_set_rk[i];
          end
        end
        ST_EXEC:    w_state_nx[i] = bus.fu_done[i] ? ST_WAIT_WB : ST_EXEC;
        ST_WAIT_WB: w_state_nx[i] = w_write_go[i] ? ST_IDLE : ST_WAIT_WB;
        default:    w_state_nx[i] = ST_IDLE;
      endcase
    end
    // Free before claim: a writeback dest can never equal a legal issue dest.
    for (int r = 0; r < NUM_REGS; r++) begin
      for (int f = 0; f < NUM_FU; f++) begin
        w_regstat_nx[r] = (w_write_go[f] && (r_fi[f] == REG_W'(r)) && (r_fi[f] != NO_WR)) ?
                          FU_FREE : w_regstat_nx[r];
      end
      w_regstat_nx[r] = (w_fire && (bus.issue_dest == REG_W'(r)) && (bus.issue_dest != NO_WR)) ?
                        w_sel_fu : w_regstat_nx[r];
    end
  end

  // State registers; reset discards all in-flight work.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_FU; i++) begin
        r_state[i] <= ST_IDLE;
        r_fi[i]    <= NO_WR;
        r_fj[i]    <= '0;
        r_fk[i]    <= '0;
        r_qj[i]    <= FU_FREE;
        r_qk[i]    <= FU_FREE;
      end
      r_rj <= '0;
      r_rk <= '0;
      for (int r = 0; r < NUM_REGS; r++) begin
        r_regstat[r] <= FU_FREE;
      end
    end else begin
      r_state   <= w_state_nx;
      r_fi      <= w_fi_nx;
      r_fj      <= w_fj_nx;
      r_fk      <= w_fk_nx;
      r_qj      <= w_qj_nx;
      r_qk      <= w_qk_nx;
      r_rj      <= w_rj_nx;
      r_rk      <= w_rk_nx;
      r_regstat <= w_regstat_nx;
    end
  end

  assign bus.issue_ready = w_issue_ready;
  assign bus.issue_fu    = w_sel_fu;
  assign bus.fu_read_go  = w_read_go;
  assign bus.fu_write_go = w_write_go;
  assign bus.fu_busy     = w_busy;
endmodule
